// File: rtl/sa_sequencer.sv
// sa_sequencer: job sequencer for a small systolic array.
// A job loads LOAD_BYTES bytes from the host and streams them into the array
// in load order. It then waits for the array's ack, with a TIMEOUT-cycle
// limit, captures RES_BYTES result bytes and hands them to the consumer over
// a valid/ready interface.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   host_valid/data/ready    load-byte stream from the host
//   sa_en, sa_shift_in       array start/shift enable and streamed byte
//   sa_shift_out, sa_ack     result byte from the array and completion flag
//   res_valid/data/ready     result-byte stream to the consumer
//   busy                     high in every state except idle
//   err                      sticky timeout flag, cleared by the next job's first byte
module sa_sequencer #(
    parameter int unsigned LOAD_BYTES = 32,
    parameter int unsigned RES_BYTES  = 16,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       host_valid,
    input  logic [7:0] host_data,
    output logic       host_ready,
    output logic       sa_en,
    output logic [7:0] sa_shift_in,
    input  logic [7:0] sa_shift_out,
    input  logic       sa_ack,
    output logic       res_valid,
    output logic [7:0] res_data,
    input  logic       res_ready,
    output logic       busy,
    output logic       err
);

    // Buffers are rounded up to a power of two so pointer widths match exactly.
    localparam int unsigned LW     = (LOAD_BYTES > 1) ? $clog2(LOAD_BYTES) : 1;
    localparam int unsigned RW     = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;
    localparam int unsigned LDepth = 1 << LW;
    localparam int unsigned RDepth = 1 << RW;

    localparam logic [LW-1:0] LoadLast    = LW'(LOAD_BYTES - 1);
    localparam logic [RW-1:0] ResLast     = RW'(RES_BYTES - 1);
    localparam logic [15:0]   TimeoutLast = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StShift, StWait, StCapture, StOut
    } state_e;

    state_e      state_q, state_d;
    // ld_ptr: write pointer during LOAD, read pointer during SHIFT.
    logic [LW-1:0] ld_ptr_q, ld_ptr_d;
    // rs_ptr: write pointer during CAPTURE, read pointer during OUT.
    logic [RW-1:0] rs_ptr_q, rs_ptr_d;
    logic [15:0]   wait_cnt_q, wait_cnt_d;
    logic          err_q, err_d;
    logic [7:0]    load_buf_q [LDepth];
    logic [7:0]    load_buf_d [LDepth];
    logic [7:0]    res_buf_q  [RDepth];
    logic [7:0]    res_buf_d  [RDepth];

    always_comb begin
        state_d     = state_q;
        ld_ptr_d    = ld_ptr_q;
        rs_ptr_d    = rs_ptr_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        load_buf_d  = load_buf_q;
        res_buf_d   = res_buf_q;
        host_ready  = 1'b0;
        sa_en       = 1'b0;
        sa_shift_in = 8'h00;
        res_valid   = 1'b0;
        res_data    = 8'h00;

        unique case (state_q)
            StIdle: begin
                host_ready = 1'b1;
                if (host_valid) begin
                    load_buf_d[0] = host_data;
                    err_d         = 1'b0;
                    if (LOAD_BYTES == 1) begin
                        ld_ptr_d = '0;
                        state_d  = StShift;
                    end else begin
                        ld_ptr_d = LW'(1);
                        state_d  = StLoad;
                    end
                end
            end
            StLoad: begin
                host_ready = 1'b1;
                if (host_valid) begin
                    load_buf_d[ld_ptr_q] = host_data;
                    if (ld_ptr_q == LoadLast) begin
                        ld_ptr_d = '0;
                        state_d  = StShift;
                    end else begin
                        ld_ptr_d = ld_ptr_q + LW'(1);
                    end
                end
            end
            StShift: begin
                sa_en       = 1'b1;
                sa_shift_in = load_buf_q[ld_ptr_q];
                if (ld_ptr_q == LoadLast) begin
                    ld_ptr_d   = '0;
                    wait_cnt_d = '0;
                    state_d    = StWait;
                end else begin
                    ld_ptr_d = ld_ptr_q + LW'(1);
                end
            end
            StWait: begin
                // Ack takes priority over an expiring counter.
                if (sa_ack) begin
                    rs_ptr_d = '0;
                    state_d  = StCapture;
                end else if (wait_cnt_q == TimeoutLast) begin
                    err_d      = 1'b1;
                    ld_ptr_d   = '0;
                    rs_ptr_d   = '0;
                    wait_cnt_d = '0;
                    state_d    = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            StCapture: begin
                res_buf_d[rs_ptr_q] = sa_shift_out;
                if (rs_ptr_q == ResLast) begin
                    rs_ptr_d = '0;
                    state_d  = StOut;
                end else begin
                    rs_ptr_d = rs_ptr_q + RW'(1);
                end
            end
            StOut: begin
                res_valid = 1'b1;
                res_data  = res_buf_q[rs_ptr_q];
                if (res_ready) begin
                    if (rs_ptr_q == ResLast) begin
                        rs_ptr_d = '0;
                        state_d  = StIdle;
                    end else begin
                        rs_ptr_d = rs_ptr_q + RW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);
    assign err  = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ld_ptr_q   <= '0;
            rs_ptr_q   <= '0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_ptr_q   <= ld_ptr_d;
            rs_ptr_q   <= rs_ptr_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    // Data buffers need no reset: every job rewrites each entry before it is read.
    always_ff @(posedge clk) begin
        load_buf_q <= load_buf_d;
        res_buf_q  <= res_buf_d;
    end

endmodule
